// File: rtl/clkdiv_pkg.sv
// Shared definitions for the tick scheduler.
//   CD_CW        default divisor/counter width
//   CD_NCH       default number of tick channels
//   CD_DEF_DIVn  reset divisors for channels 0..3 (100 MHz master clock)
//   state_t      scheduler state encoding (ST_IDLE, ST_RUN, ST_PAUSED)
package clkdiv_pkg;

  localparam int CD_CW  = 32;
  localparam int CD_NCH = 4;

  localparam logic [CD_CW-1:0] CD_DEF_DIV0 = 32'd4;          // 25 MHz pixel enable
  localparam logic [CD_CW-1:0] CD_DEF_DIV1 = 32'd262144;     // ~381 Hz segment scan
  localparam logic [CD_CW-1:0] CD_DEF_DIV2 = 32'd200000;     // 500 Hz game tick
  localparam logic [CD_CW-1:0] CD_DEF_DIV3 = 32'd100000000;  // 1 Hz score tick

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_PAUSED = 2'd2;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counter, divisor register, wrap detect and registered tick.
// Ports:
//   clk_i, clr_n_i  clock, async active-low reset (div returns to DEF_DIV)
//   en_i            count this cycle
//   clr_i           force counter to 0 and suppress the tick (idle/stop/resync)
//   apply_i         load apply_div_i into the divisor register
//   apply_div_i     divisor value to load
//   wrap_o          counter sits on its last value (div-1)
//   tick_o          one-cycle strobe, the cycle after a counted wrap
module tick_channel #(
  parameter int             CW      = 32,
  parameter logic [CW-1:0]  DEF_DIV = CW'(1)
) (
  input  logic          clk_i,
  input  logic          clr_n_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic          apply_i,
  input  logic [CW-1:0] apply_div_i,
  output logic          wrap_o,
  output logic          tick_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] last;
  logic          tick_q, tick_d;

  // A zero divisor behaves like one: wrap every counted cycle.
  assign last   = (div_q == '0) ? '0 : div_q - CW'(1);
  assign wrap_o = (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick_d = en_i & wrap_o & ~clr_i;
  assign div_d  = apply_i ? apply_div_i : div_q;

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      cnt_q  <= '0;
      div_q  <= DEF_DIV;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable scheduler with run/pause/stop sequencing and a
// single-slot divisor write port. Optional macro TICK_RESYNC_EN adds resync_i.
// Ports:
//   clk_i        master clock (100 MHz)
//   clr_n_i      async active-low reset
//   start_i      IDLE->RUN, PAUSED->RUN
//   pause_i      RUN->PAUSED
//   stop_i       any state -> IDLE, counters cleared
//   cfg_valid_i  divisor write request; transfer when cfg_valid_i & cfg_ready_o
//   cfg_ready_o  write slot free
//   cfg_ch_i     target channel (>= NCH accepted and dropped)
//   cfg_div_i    new divisor
//   tick_o       one-cycle strobes, registered
//   running_o    high while in RUN
//   resync_i     (TICK_RESYNC_EN only) zero all counters while running
//
// state      | meaning
// ST_IDLE    | counters held at 0, no ticks, pending write applied at once
// ST_RUN     | counters advance, ticks on wrap, pending write applied at wrap
// ST_PAUSED  | counters frozen, no ticks, pending write held
module tick_scheduler
  import clkdiv_pkg::*;
#(
  parameter int            NCH      = CD_NCH,
  parameter int            CW       = CD_CW,
  parameter logic [CW-1:0] DEF_DIV0 = CD_DEF_DIV0,
  parameter logic [CW-1:0] DEF_DIV1 = CD_DEF_DIV1,
  parameter logic [CW-1:0] DEF_DIV2 = CD_DEF_DIV2,
  parameter logic [CW-1:0] DEF_DIV3 = CD_DEF_DIV3
) (
  input  logic           clk_i,
  input  logic           clr_n_i,
  input  logic           start_i,
  input  logic           pause_i,
  input  logic           stop_i,
  input  logic           cfg_valid_i,
  output logic           cfg_ready_o,
  input  logic [1:0]     cfg_ch_i,
  input  logic [CW-1:0]  cfg_div_i,
  output logic [NCH-1:0] tick_o,
  output logic           running_o
`ifdef TICK_RESYNC_EN
  ,input logic           resync_i
`endif
);

  localparam logic [4*CW-1:0] DEF_PACK = {DEF_DIV3, DEF_DIV2, DEF_DIV1, DEF_DIV0};

  state_t        st_q, st_d;
  logic          pend_q, pend_d;
  logic [1:0]    pch_q, pch_d;
  logic [CW-1:0] pdiv_q, pdiv_d;

  logic           resync;
  logic           run_en;
  logic           clr_cnt;
  logic [NCH-1:0] wrap;
  logic [NCH-1:0] apply;

`ifdef TICK_RESYNC_EN
  assign resync = resync_i;
`else
  assign resync = 1'b0;
`endif

  // The cycle that samples pause or stop no longer counts, so a paused
  // scheduler never emits a tick and resumes exactly where it stopped.
  assign run_en  = (st_q == ST_RUN) && !stop_i && !pause_i;
  assign clr_cnt = (st_q == ST_IDLE) || stop_i || (run_en && resync);

  always_comb begin
    st_d = st_q;
    if (stop_i) begin
      st_d = ST_IDLE;
    end else if (pause_i) begin
      if (st_q == ST_RUN) st_d = ST_PAUSED;
    end else if (start_i) begin
      if (st_q == ST_IDLE || st_q == ST_PAUSED) st_d = ST_RUN;
    end
    if (st_q != ST_IDLE && st_q != ST_RUN && st_q != ST_PAUSED) st_d = ST_IDLE;
  end

  always_comb begin
    pend_d = pend_q;
    pch_d  = pch_q;
    pdiv_d = pdiv_q;
    if (|apply) pend_d = 1'b0;
    if (cfg_valid_i && !pend_q && (int'(cfg_ch_i) < NCH)) begin
      pend_d = 1'b1;
      pch_d  = cfg_ch_i;
      pdiv_d = cfg_div_i;
    end
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      st_q   <= ST_IDLE;
      pend_q <= 1'b0;
      pch_q  <= '0;
      pdiv_q <= '0;
    end else begin
      st_q   <= st_d;
      pend_q <= pend_d;
      pch_q  <= pch_d;
      pdiv_q <= pdiv_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Outside IDLE the new divisor waits for this channel's own wrap so the
    // period in flight finishes with the old value.
    assign apply[i] = pend_q && (pch_q == 2'(i)) &&
                      ((st_q == ST_IDLE) || (run_en && wrap[i]));

    tick_channel #(
      .CW      (CW),
      .DEF_DIV (DEF_PACK[i*CW +: CW])
    ) u_ch (
      .clk_i       (clk_i),
      .clr_n_i     (clr_n_i),
      .en_i        (run_en),
      .clr_i       (clr_cnt),
      .apply_i     (apply[i]),
      .apply_div_i (pdiv_q),
      .wrap_o      (wrap[i]),
      .tick_o      (tick_o[i])
    );
  end

  assign running_o   = (st_q == ST_RUN);
  assign cfg_ready_o = ~pend_q;

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

  localparam int NCH = 4;

  logic        clk_i = 1'b0;
  logic        clr_n_i;
  logic        start_i, pause_i, stop_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [1:0]  cfg_ch_i;
  logic [31:0] cfg_div_i;
  logic [3:0]  tick_o;
  logic        running_o;

  always #5 clk_i = ~clk_i;

  tick_scheduler dut (
    .clk_i       (clk_i),
    .clr_n_i     (clr_n_i),
    .start_i     (start_i),
    .pause_i     (pause_i),
    .stop_i      (stop_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_div_i   (cfg_div_i),
    .tick_o      (tick_o),
    .running_o   (running_o)
`ifdef TICK_RESYNC_EN
    ,.resync_i   (1'b0)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // Reference model: each channel tracks how many running cycles have elapsed
  // in its current period; a period of length P ends after P counted cycles.
  int         m_mode;        // 0 idle, 1 run, 2 paused
  int         m_elapsed[4];
  longint     m_div[4];
  bit         m_pend;
  int         m_pch;
  longint     m_pdiv;
  bit [3:0]   m_tick;

  function automatic longint def_div(input int ch);
    case (ch)
      0:       return 4;
      1:       return 262144;
      2:       return 200000;
      default: return 100000000;
    endcase
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    for (int c = 0; c < 4; c++) begin
      m_elapsed[c] = 0;
      m_div[c]     = def_div(c);
    end
    m_pend = 0;
    m_pch  = 0;
    m_pdiv = 0;
    m_tick = '0;
  endfunction

  function automatic void model_edge();
    bit       counting = (m_mode == 1) && !stop_i && !pause_i;
    bit       had_pend = m_pend;
    bit [3:0] nt       = '0;
    longint   period;
    for (int c = 0; c < 4; c++) begin
      if (m_mode == 0 || stop_i) begin
        m_elapsed[c] = 0;
      end else if (counting) begin
        m_elapsed[c]++;
        period = (m_div[c] == 0) ? 1 : m_div[c];
        if (m_elapsed[c] >= period) begin
          m_elapsed[c] = 0;
          nt[c] = 1'b1;
          if (had_pend && m_pch == c) begin
            m_div[c] = m_pdiv;
            m_pend   = 0;
          end
        end
      end
    end
    if (m_mode == 0 && had_pend) begin
      m_div[m_pch] = m_pdiv;
      m_pend       = 0;
    end
    if (cfg_valid_i && !had_pend && int'(cfg_ch_i) < NCH) begin
      m_pend = 1;
      m_pch  = int'(cfg_ch_i);
      m_pdiv = longint'(cfg_div_i);
    end
    if (stop_i)                        m_mode = 0;
    else if (pause_i)                  m_mode = (m_mode == 1) ? 2 : m_mode;
    else if (start_i && m_mode != 1)   m_mode = 1;
    m_tick = nt;
  endfunction

  task automatic step();
    @(posedge clk_i);
    if (clr_n_i) model_edge();
    #1;
    chk("tick", tick_o, m_tick);
    chk("running", running_o, m_mode == 1);
    chk("cfg_ready", cfg_ready_o, !m_pend);
  endtask

  task automatic cyc(input bit s, input bit p, input bit t);
    start_i = s; pause_i = p; stop_i = t;
    step();
    start_i = 0; pause_i = 0; stop_i = 0;
  endtask

  task automatic wr(input int ch, input longint d);
    cfg_valid_i = 1; cfg_ch_i = 2'(ch); cfg_div_i = 32'(d);
    step();
    cfg_valid_i = 0;
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (!cfg_ready_o && k < budget) begin
      step();
      k++;
    end
    chk("ready_wait", cfg_ready_o, 1);
  endtask

  task automatic wait_tick(input int ch, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (tick_o[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, cnt;
    clr_n_i = 0; start_i = 0; pause_i = 0; stop_i = 0;
    cfg_valid_i = 0; cfg_ch_i = 0; cfg_div_i = 0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_tick", tick_o, 0);
    chk("rst_running", running_o, 0);
    chk("rst_ready", cfg_ready_o, 1);
    clr_n_i = 1;

    // ch0 default divisor 4: ticks 4, 8, 12 cycles after the first RUN cycle
    step();
    cyc(1, 0, 0);
    wait_tick(0, 20, n); chk("ch0_first", n, 4);
    wait_tick(0, 20, n); chk("ch0_second_gap", n, 4);
    wait_tick(0, 20, n); chk("ch0_third_gap", n, 4);

    // pause keeps the phase
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    step(); step();
    cyc(0, 1, 0);
    repeat (5) step();
    chk("paused_running", running_o, 0);
    cyc(1, 0, 0);
    wait_tick(0, 20, n); chk("resume_phase", n, 2);
    repeat (6) step();

    // mid-period divisor change: old period completes, then period 3
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    step();
    wr(0, 3);
    chk("ready_low_pending", cfg_ready_o, 0);
    wait_tick(0, 10, n); chk("old_period_end", n, 2);
    chk("ready_after_apply", cfg_ready_o, 1);
    wait_tick(0, 10, n); chk("new_period", n, 3);
    wait_tick(0, 10, n); chk("new_period_again", n, 3);

    // stop beats pause and start in the same cycle
    cyc(1, 1, 1);
    chk("stop_prio_running", running_o, 0);
    chk("stop_prio_tick", tick_o, 0);
    step();

    // div 0 and div 1 on ch1 both tick every running cycle
    wr(1, 0);
    step();
    cyc(1, 0, 0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin step(); cnt += int'(tick_o[1]); end
    chk("div0_every_cycle", cnt, 6);
    cyc(0, 0, 1);
    wr(1, 1);
    step();
    cyc(1, 0, 0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin step(); cnt += int'(tick_o[1]); end
    chk("div1_every_cycle", cnt, 6);

    // reset mid-run with a pending write
    wr(2, 5);
    repeat (3) step();
    #2 clr_n_i = 0;
    #1;
    chk("midrst_tick", tick_o, 0);
    chk("midrst_running", running_o, 0);
    chk("midrst_ready", cfg_ready_o, 1);
    model_reset();
    @(negedge clk_i);
    clr_n_i = 1;
    step();
    cyc(1, 0, 0);
    wait_tick(0, 20, n); chk("midrst_def_div0", n, 4);
    repeat (30) step();

    // randomized run with small divisors on every channel
    cyc(0, 0, 1);
    for (int c = 0; c < 4; c++) begin
      wait_ready(20);
      wr(c, longint'($urandom_range(0, 9)));
    end
    wait_ready(20);
    for (int k = 0; k < 2500; k++) begin
      start_i     = ($urandom_range(0, 5) == 0);
      pause_i     = ($urandom_range(0, 23) == 0);
      stop_i      = ($urandom_range(0, 63) == 0);
      cfg_valid_i = ($urandom_range(0, 3) == 0);
      cfg_ch_i    = 2'($urandom_range(0, 3));
      cfg_div_i   = 32'($urandom_range(0, 9));
      step();
    end
    start_i = 0; pause_i = 0; stop_i = 0; cfg_valid_i = 0;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
